// File: rtl/regmap_rename_ctrl_if.sv
// Rename controller bus: dispatch handshake, regmap lookup/rename ports,
// retire strobe, operand-valid strobe and ROB occupancy.
//   slave  : the rename controller (consumes i_*, drives o_*)
//   master : the surrounding pipeline / testbench
interface regmap_rename_ctrl_if #(
  parameter int TAG_WIDTH = 5,
  parameter int REG_WIDTH = 5
);
  logic                 i_flush;
  logic                 i_dispatch_valid;
  logic                 o_dispatch_ready;
  logic [REG_WIDTH-1:0] i_dispatch_rsrc0;
  logic [REG_WIDTH-1:0] i_dispatch_rsrc1;
  logic [REG_WIDTH-1:0] i_dispatch_rdest;
  logic                 i_dispatch_wr_rd;
  logic                 o_regmap_lookup_valid;
  logic [REG_WIDTH-1:0] o_regmap_lookup_rsrc0;
  logic [REG_WIDTH-1:0] o_regmap_lookup_rsrc1;
  logic                 o_regmap_rename_en;
  logic [REG_WIDTH-1:0] o_regmap_rename_rdest;
  logic [TAG_WIDTH-1:0] o_regmap_rename_tag;
  logic                 i_retire_en;
  logic                 o_operands_valid;
  logic [TAG_WIDTH-1:0] o_operands_tag;
  logic [TAG_WIDTH:0]   o_rob_count;
  logic                 o_rob_full;

  modport slave (
    input  i_flush, i_dispatch_valid, i_dispatch_rsrc0, i_dispatch_rsrc1,
           i_dispatch_rdest, i_dispatch_wr_rd, i_retire_en,
    output o_dispatch_ready, o_regmap_lookup_valid, o_regmap_lookup_rsrc0,
           o_regmap_lookup_rsrc1, o_regmap_rename_en, o_regmap_rename_rdest,
           o_regmap_rename_tag, o_operands_valid, o_operands_tag,
           o_rob_count, o_rob_full
  );

  modport master (
    output i_flush, i_dispatch_valid, i_dispatch_rsrc0, i_dispatch_rsrc1,
           i_dispatch_rdest, i_dispatch_wr_rd, i_retire_en,
    input  o_dispatch_ready, o_regmap_lookup_valid, o_regmap_lookup_rsrc0,
           o_regmap_lookup_rsrc1, o_regmap_rename_en, o_regmap_rename_rdest,
           o_regmap_rename_tag, o_operands_valid, o_operands_tag,
           o_rob_count, o_rob_full
  );
endinterface

// File: rtl/regmap_rename_ctrl.sv
// Rename-stage controller. Allocates ROB tags from a circular allocator,
// drives regmap lookup/rename strobes in the accept cycle, frees tags on
// retire and holds dispatch off for a fixed window after a flush.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : regmap_rename_ctrl_if.slave (dispatch, regmap, retire,
//                operand strobe, ROB occupancy)
module regmap_rename_ctrl #(
  parameter int TAG_WIDTH    = 5,
  parameter int REG_WIDTH    = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  regmap_rename_ctrl_if.slave   bus
);
  localparam int ROB_DEPTH = 1 << TAG_WIDTH;
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e               state_q;
  logic [TAG_WIDTH-1:0] head_q, tail_q;
  logic [TAG_WIDTH:0]   count_q;
  logic [3:0]           flush_cnt_q;
  logic                 opv_q;
  logic [TAG_WIDTH-1:0] optag_q;

  logic full, ready, accept, retire;

  assign full   = (count_q == (TAG_WIDTH+1)'(ROB_DEPTH));
  // n_rst gating keeps every regmap strobe quiet while reset is held.
  assign ready  = n_rst & (state_q == RUN) & ~full & ~bus.i_flush;
  assign accept = bus.i_dispatch_valid & ready;
  // Flush wins over retire; an empty ROB has nothing to retire.
  assign retire = bus.i_retire_en & (count_q != '0) & (state_q == RUN) & ~bus.i_flush;

  assign bus.o_dispatch_ready      = ready;
  assign bus.o_regmap_lookup_valid = accept;
  assign bus.o_regmap_lookup_rsrc0 = bus.i_dispatch_rsrc0;
  assign bus.o_regmap_lookup_rsrc1 = bus.i_dispatch_rsrc1;
  // r0 is hardwired, never renamed; the tag is still consumed.
  assign bus.o_regmap_rename_en    = accept & bus.i_dispatch_wr_rd & (bus.i_dispatch_rdest != '0);
  assign bus.o_regmap_rename_rdest = bus.i_dispatch_rdest;
  assign bus.o_regmap_rename_tag   = tail_q;
  assign bus.o_operands_valid      = opv_q;
  assign bus.o_operands_tag        = optag_q;
  assign bus.o_rob_count           = count_q;
  assign bus.o_rob_full            = full;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= RUN;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
      opv_q       <= 1'b0;
      optag_q     <= '0;
    end else begin
      // One-cycle delay lines up with the regmap's registered lookup data;
      // accept is already zero in a flush cycle.
      opv_q <= accept;
      if (accept) optag_q <= tail_q;

      if (bus.i_flush) begin
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        flush_cnt_q <= FLUSH_RELOAD;
        state_q     <= FLUSH;
      end else begin
        if (accept) tail_q <= tail_q + 1'b1;
        if (retire) head_q <= head_q + 1'b1;
        if (accept && !retire)      count_q <= count_q + 1'b1;
        else if (!accept && retire) count_q <= count_q - 1'b1;

        if (state_q == FLUSH) begin
          if (flush_cnt_q == '0) state_q <= RUN;
          else                   flush_cnt_q <= flush_cnt_q - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regmap_rename_ctrl.sv
module tb_regmap_rename_ctrl;
  localparam int TW = 5, RW = 5, FC = 2, DEPTH = 32;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  regmap_rename_ctrl_if #(.TAG_WIDTH(TW), .REG_WIDTH(RW)) bus ();

  regmap_rename_ctrl #(.TAG_WIDTH(TW), .REG_WIDTH(RW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy, next tag, and cycles of dispatch blackout
  // still owed after a flush.
  int m_count, m_tail, m_hold, m_optag;
  bit m_opv;

  function automatic bit m_ready();
    return n_rst && m_hold == 0 && m_count < DEPTH && !bus.i_flush;
  endfunction

  function automatic bit m_acc();
    return bus.i_dispatch_valid && m_ready();
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_count = 0; m_tail = 0; m_hold = 0; m_opv = 0; m_optag = 0;
    end else begin
      bit acc, ret;
      acc = m_acc();
      ret = bus.i_retire_en && m_count > 0 && m_hold == 0 && !bus.i_flush;
      m_opv = acc;
      if (acc) m_optag = m_tail;
      if (bus.i_flush) begin
        m_count = 0; m_tail = 0; m_hold = FC;
      end else begin
        if (acc) m_tail = (m_tail + 1) % DEPTH;
        m_count = m_count + int'(acc) - int'(ret);
        if (m_hold > 0) m_hold--;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    bit acc;
    acc = m_acc();
    chk("ready", bus.o_dispatch_ready, m_ready());
    chk("lookup_valid", bus.o_regmap_lookup_valid, acc);
    chk("lookup_rsrc0", bus.o_regmap_lookup_rsrc0, bus.i_dispatch_rsrc0);
    chk("lookup_rsrc1", bus.o_regmap_lookup_rsrc1, bus.i_dispatch_rsrc1);
    chk("rename_en", bus.o_regmap_rename_en,
        acc && bus.i_dispatch_wr_rd && bus.i_dispatch_rdest != 0);
    chk("rename_rdest", bus.o_regmap_rename_rdest, bus.i_dispatch_rdest);
    if (acc) chk("rename_tag", bus.o_regmap_rename_tag, m_tail);
    chk("operands_valid", bus.o_operands_valid, m_opv);
    chk("operands_tag", bus.o_operands_tag, m_optag);
    chk("rob_count", bus.o_rob_count, m_count);
    chk("rob_full", bus.o_rob_full, m_count == DEPTH);
  end

  // Apply inputs for one cycle, then stop at the sampling point.
  task automatic go(input bit v, input int rd, input bit wr, input bit ret, input bit fl);
    bus.i_dispatch_valid = v;
    bus.i_dispatch_rdest = RW'(rd);
    bus.i_dispatch_wr_rd = wr;
    bus.i_retire_en      = ret;
    bus.i_flush          = fl;
    bus.i_dispatch_rsrc0 = RW'($urandom_range(0, 31));
    bus.i_dispatch_rsrc1 = RW'($urandom_range(0, 31));
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a dispatch pending: no strobes may escape.
    n_rst = 1'b0;
    go(1, 9, 1, 1, 0);
    chk("rst_lookup_valid", bus.o_regmap_lookup_valid, 0);
    chk("rst_rename_en", bus.o_regmap_rename_en, 0);
    nxt();
    n_rst = 1'b1;
    go(0, 0, 0, 0, 0);
    chk("rst_ready", bus.o_dispatch_ready, 1);
    chk("rst_count", bus.o_rob_count, 0);
    chk("rst_full", bus.o_rob_full, 0);
    chk("rst_opv", bus.o_operands_valid, 0);
    nxt();

    // Back-to-back dispatches take tags 0,1,2; operands follow a cycle later.
    for (int i = 0; i < 3; i++) begin
      go(1, 5 + i, 1, 0, 0);
      chk("d1_tag", bus.o_regmap_rename_tag, i);
      chk("d1_rename_en", bus.o_regmap_rename_en, 1);
      if (i > 0) chk("d1_opv_tag", bus.o_operands_tag, i - 1);
      nxt();
    end
    go(0, 0, 0, 0, 0);
    chk("d1_opv_last", bus.o_operands_valid, 1);
    chk("d1_opv_tag_last", bus.o_operands_tag, 2);
    chk("d1_count", bus.o_rob_count, 3);
    nxt();

    // rdest=0 and wr_rd=0 consume tags without renaming.
    go(1, 0, 1, 0, 0);
    chk("d2_r0_rename_en", bus.o_regmap_rename_en, 0);
    chk("d2_r0_lookup", bus.o_regmap_lookup_valid, 1);
    chk("d2_r0_tag", bus.o_regmap_rename_tag, 3);
    nxt();
    go(1, 3, 0, 0, 0);
    chk("d2_nowr_rename_en", bus.o_regmap_rename_en, 0);
    chk("d2_nowr_tag", bus.o_regmap_rename_tag, 4);
    nxt();

    // Flush alongside a dispatch at count=5: three-cycle blackout.
    go(1, 4, 1, 0, 1);
    chk("fl_ready0", bus.o_dispatch_ready, 0);
    chk("fl_lookup", bus.o_regmap_lookup_valid, 0);
    nxt();
    go(1, 4, 1, 0, 0);
    chk("fl_opv", bus.o_operands_valid, 0);
    chk("fl_count", bus.o_rob_count, 0);
    chk("fl_ready1", bus.o_dispatch_ready, 0);
    nxt();
    go(1, 4, 1, 1, 0);
    chk("fl_ready2", bus.o_dispatch_ready, 0);
    chk("fl_retire_ignored", bus.o_rob_count, 0);
    nxt();
    go(1, 4, 1, 0, 0);
    chk("fl_ready3", bus.o_dispatch_ready, 1);
    chk("fl_tag", bus.o_regmap_rename_tag, 0);
    nxt();

    // Drain, then retire on an empty ROB.
    go(0, 0, 0, 1, 0); nxt();
    go(0, 0, 0, 1, 0);
    chk("empty_retire_count", bus.o_rob_count, 0);
    nxt();

    // Flush to rewind the tail, then fill all 32 tags.
    go(0, 0, 0, 0, 1); nxt();
    go(0, 0, 0, 1, 0); nxt();
    go(0, 0, 0, 0, 0); nxt();
    for (int i = 0; i < DEPTH; i++) begin
      go(1, 1 + (i % 31), 1, 0, 0);
      chk("fill_tag", bus.o_regmap_rename_tag, i);
      nxt();
    end
    go(1, 2, 1, 1, 0);
    chk("full_flag", bus.o_rob_full, 1);
    chk("full_ready", bus.o_dispatch_ready, 0);
    chk("full_count", bus.o_rob_count, 32);
    chk("full_no_accept", bus.o_regmap_lookup_valid, 0);
    nxt();
    go(1, 2, 1, 0, 0);
    chk("unfull_count", bus.o_rob_count, 31);
    chk("unfull_ready", bus.o_dispatch_ready, 1);
    chk("wrap_tag", bus.o_regmap_rename_tag, 0);
    nxt();

    // Retire down to 10, then accept+retire together.
    for (int i = 0; i < 22; i++) begin go(0, 0, 0, 1, 0); nxt(); end
    go(1, 6, 1, 1, 0);
    chk("ar_count_before", bus.o_rob_count, 10);
    nxt();
    go(0, 0, 0, 0, 0);
    chk("ar_count_after", bus.o_rob_count, 10);
    nxt();

    // Randomized traffic with occasional flush and mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      n_rst = ($urandom_range(0, 299) != 0);
      go($urandom_range(0, 9) < 7, $urandom_range(0, 31), $urandom_range(0, 3) != 0,
         $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0);
      nxt();
    end
    n_rst = 1'b1;
    go(0, 0, 0, 0, 0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regmap_rename_ctrl.md
Name: regmap_rename_ctrl

Overview:
- Rename-stage controller that sequences the register map for each dispatched instruction.
- Allocates ROB tags from a circular allocator and drives the regmap source lookup and destination rename ports.
- Frees tags on retire and recovers from flushes with a timed flush-recovery state machine.
- Sits between decode/dispatch and the register map/ROB; emits a one-cycle-delayed "operands valid" strobe aligned with the regmap's registered lookup outputs.

Parameters:
- TAG_WIDTH, 5, width of ROB tag; ROB_DEPTH = 2**TAG_WIDTH (32).
- REG_WIDTH, 5, architectural register index width.
- FLUSH_CYCLES, 2, cycles dispatch is held off after a flush (range 1..15).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- i_flush  in  1  pipeline flush (branch/exception)
- i_dispatch_valid  in  1  decoded instruction available
- o_dispatch_ready  out  1  controller accepts instruction this cycle
- i_dispatch_rsrc0  in  REG_WIDTH  source register 0
- i_dispatch_rsrc1  in  REG_WIDTH  source register 1
- i_dispatch_rdest  in  REG_WIDTH  destination register
- i_dispatch_wr_rd  in  1  instruction writes rdest
- o_regmap_lookup_valid  out  1  regmap lookup strobe
- o_regmap_lookup_rsrc0  out  REG_WIDTH  lookup source 0
- o_regmap_lookup_rsrc1  out  REG_WIDTH  lookup source 1
- o_regmap_rename_en  out  1  regmap tag update enable
- o_regmap_rename_rdest  out  REG_WIDTH  register being renamed
- o_regmap_rename_tag  out  TAG_WIDTH  tag written to regmap
- i_retire_en  in  1  ROB retired head entry
- o_operands_valid  out  1  regmap lookup results valid this cycle
- o_operands_tag  out  TAG_WIDTH  tag of instruction whose operands are valid
- o_rob_count  out  TAG_WIDTH+1  allocated tag count
- o_rob_full  out  1  count == ROB_DEPTH

Behaviour:
- State machine: RUN, FLUSH.
- Reset (async, n_rst low): state=RUN, head=0, tail=0, count=0, flush_cnt=0, o_operands_valid=0, o_operands_tag=0.
- After reset, o_dispatch_ready=1, o_rob_full=0, o_rob_count=0; all regmap strobes 0.
- o_dispatch_ready = (state==RUN) & ~o_rob_full & ~i_flush. Combinational; independent of i_dispatch_valid.
- accept = i_dispatch_valid & o_dispatch_ready.
- Lookup/rename outputs are combinational, same cycle as accept:
  - o_regmap_lookup_valid = accept; lookup rsrc ports = dispatch rsrc ports.
  - o_regmap_rename_en = accept & i_dispatch_wr_rd & (rdest != 0).
  - o_regmap_rename_rdest = i_dispatch_rdest; o_regmap_rename_tag = tail.
- Tag allocation: tail advances on every accept, including no-write instructions. All pointers are TAG_WIDTH wide and wrap naturally (31 -> 0).
- Retire: if i_retire_en & count != 0 & state==RUN, head increments. i_retire_en while count==0 is ignored and count stays 0.
- Count update:
  - accept & retire same cycle: count unchanged.
  - accept only: +1.
  - retire only: -1.
- Operand strobe: o_operands_valid <= accept & ~i_flush next cycle; o_operands_tag <= tail at accept. This aligns with the regmap's registered lookup outputs.
- Flush: i_flush has priority over accept and retire.
  - In the flush cycle: head<=0, tail<=0, count<=0, o_operands_valid<=0, flush_cnt<=FLUSH_CYCLES-1, state<=FLUSH.
  - FLUSH: dispatch_ready=0; retire ignored; flush_cnt decrements each cycle; at flush_cnt==0 and no new i_flush, state<=RUN.
  - i_flush asserted again during FLUSH reloads flush_cnt.
  - Total dispatch blackout = 1 (flush cycle) + FLUSH_CYCLES cycles.
- Full: at count==ROB_DEPTH, ready=0. A retire in the full cycle does not enable same-cycle accept; ready rises next cycle.
- Reset asserted mid-operation: immediate return to reset values; no regmap strobes while n_rst low.

Test Plan:
- Reset then 3 back-to-back dispatches (rdest=5,6,7, wr_rd=1) -> rename_tag 0,1,2 in consecutive cycles; o_operands_valid high cycles 2-4 with tags 0,1,2; o_rob_count=3.
- Dispatch with rdest=0 and with wr_rd=0 -> o_regmap_rename_en=0 both times; tail still advances 0->2; lookup_valid=1 both cycles.
- 32 dispatches without retire -> o_rob_full=1, ready=0 on cycle 33. One retire -> count=31, ready=1 the following cycle; next tag=0 (wrap).
- Simultaneous accept and retire at count=10 -> count stays 10; head and tail each +1.
- Flush in the same cycle as dispatch_valid with count=5 -> no accept, no operands_valid next cycle; count=0; ready low 3 cycles (FLUSH_CYCLES=2); next accepted tag=0.
- Retire at count=0 and retire during FLUSH -> count stays 0; head unchanged.
